// File: rtl/sudoku_board_checker.sv
// sudoku_board_checker: scans an N x N Sudoku board one row per cycle from a
// synchronous read-only RAM and reports per-row/column/box conflicts, the
// number of empty cells and whether the board is solved.
// RAM interface: RamAddr is presented in a READ cycle and RamDat carries that
// row on the following cycle; there is no handshake.
module sudoku_board_checker #(
  parameter int N      = 4,
  parameter int BOX    = 2,
  parameter int CELL_W = 6,
  parameter int VAL_W  = 4,
  localparam int AW    = (N > 1) ? $clog2(N) : 1,
  localparam int EW    = $clog2(N * N + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  checkEn,
  output logic [AW-1:0]         RamAddr,
  input  logic [N*CELL_W-1:0]   RamDat,
  output logic [N-1:0]          rowConflict,
  output logic [N-1:0]          colConflict,
  output logic [N-1:0]          boxConflict,
  output logic [EW-1:0]         emptyCount,
  output logic                  gameComplete,
  output logic                  scanDone,
  output logic [2:0]            stateDbg
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, COMMIT} stateT;

  localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);

  stateT state, stateNext;

  logic [AW-1:0]         rowCnt;
  logic [AW-1:0]         pendRow;
  logic                  pendValid;
  logic [N-1:0][N-1:0]   colMask;
  logic [N-1:0][N-1:0]   boxMask;
  logic [N-1:0]          wRow, wCol, wBox;
  logic [EW-1:0]         wEmpty;

  logic [N-1:0][N-1:0]   colMaskNext;
  logic [N-1:0][N-1:0]   boxMaskNext;
  logic [N-1:0]          rowMask;
  logic                  rowHit;
  logic [N-1:0]          colHit, boxHit;
  logic [EW-1:0]         rowEmpty;
  logic [VAL_W-1:0]      v;
  logic [AW-1:0]         vIdx, bIdx;
  logic                  unusedRamBits;

  // Bits above VAL_W in each cell carry no value information.
  assign unusedRamBits = ^RamDat;

  assign RamAddr  = rowCnt;
  assign stateDbg = state;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic: one CLEAR, N READs, one DRAIN, one COMMIT per scan.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (checkEn) stateNext = CLEAR;
      CLEAR:   stateNext = READ;
      READ:    if (rowCnt == LAST_ROW) stateNext = DRAIN;
      DRAIN:   stateNext = COMMIT;
      COMMIT:  stateNext = checkEn ? CLEAR : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Row accumulation: walk the cells left to right so earlier cells of the
  // same row (and same box) are already in the masks when later ones test.
  always_comb begin
    rowMask     = '0;
    rowHit      = 1'b0;
    colHit      = '0;
    boxHit      = '0;
    colMaskNext = colMask;
    boxMaskNext = boxMask;
    rowEmpty    = '0;
    v           = '0;
    vIdx        = '0;
    bIdx        = '0;
    for (int c = 0; c < N; c++) begin
      v    = RamDat[c*CELL_W +: VAL_W];
      vIdx = AW'(v - VAL_W'(1));
      bIdx = AW'((int'(pendRow) / BOX) * BOX + c / BOX);
      if (v == '0) begin
        rowEmpty = rowEmpty + EW'(1);
      end else if (int'(v) <= N) begin
        if (rowMask[vIdx])           rowHit    = 1'b1;
        if (colMaskNext[c][vIdx])    colHit[c] = 1'b1;
        if (boxMaskNext[bIdx][vIdx]) boxHit[bIdx] = 1'b1;
        rowMask[vIdx]           = 1'b1;
        colMaskNext[c][vIdx]    = 1'b1;
        boxMaskNext[bIdx][vIdx] = 1'b1;
      end else begin
        rowHit       = 1'b1;
        colHit[c]    = 1'b1;
        boxHit[bIdx] = 1'b1;
      end
    end
  end

  // Datapath: row counter, pipeline tag, working results and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rowCnt       <= '0;
      pendRow      <= '0;
      pendValid    <= 1'b0;
      colMask      <= '0;
      boxMask      <= '0;
      wRow         <= '0;
      wCol         <= '0;
      wBox         <= '0;
      wEmpty       <= '0;
      rowConflict  <= '0;
      colConflict  <= '0;
      boxConflict  <= '0;
      emptyCount   <= '0;
      gameComplete <= 1'b0;
      scanDone     <= 1'b0;
    end else begin
      scanDone <= 1'b0;
      case (state)
        CLEAR: begin
          rowCnt    <= '0;
          pendValid <= 1'b0;
          colMask   <= '0;
          boxMask   <= '0;
          wRow      <= '0;
          wCol      <= '0;
          wBox      <= '0;
          wEmpty    <= '0;
        end
        READ: begin
          pendRow   <= rowCnt;
          pendValid <= 1'b1;
          // Counter parks on the last row so RamAddr holds N-1 in DRAIN.
          if (rowCnt != LAST_ROW) rowCnt <= rowCnt + AW'(1);
        end
        DRAIN: begin
          pendValid <= 1'b0;
        end
        COMMIT: begin
          rowConflict  <= wRow;
          colConflict  <= wCol;
          boxConflict  <= wBox;
          emptyCount   <= wEmpty;
          gameComplete <= (wRow == '0) && (wCol == '0) && (wBox == '0) && (wEmpty == '0);
          scanDone     <= 1'b1;
        end
        default: ;
      endcase
      if (pendValid) begin
        colMask       <= colMaskNext;
        boxMask       <= boxMaskNext;
        wRow[pendRow] <= wRow[pendRow] | rowHit;
        wCol          <= wCol | colHit;
        wBox          <= wBox | boxHit;
        wEmpty        <= wEmpty + rowEmpty;
      end
    end
  end

endmodule
